// File: rtl/dff_scan_ctrl.sv
// -----------------------------------------------------------------------------
// dff_scan_ctrl
//   Sequencer for a serial chain of wrapped D flip-flop cells. Accepts shift,
//   capture+shift and capture-only requests over valid/ready, drives the chain
//   strobes for an exact number of cycles and gathers scan_out into a
//   parallel response word.
//
// Ports
//   clk, rst            clock shared with the chain; synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_op              00 shift, 01 capture+shift, 10 capture only, 11 illegal
//   req_data            serial data to shift in, bit 0 first
//   rsp_valid/rsp_ready response handshake
//   rsp_data            bits shifted out, bit 0 = first sampled
//   rsp_err             request was illegal
//   cap_en/scan_en      chain parallel-capture strobe / shift enable
//   scan_in/scan_out    serial data to first cell / from last cell
//   busy                high in any state other than IDLE
// -----------------------------------------------------------------------------
module dff_scan_ctrl #(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [CHAIN_LEN-1:0] req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 cap_en,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CHAIN_LEN);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_SHIFT   = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [1:0] OP_SHIFT   = 2'b00;
    localparam logic [1:0] OP_CAP_SH  = 2'b01;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    logic [1:0]           r_state;
    logic [1:0]           r_op;
    logic [CHAIN_LEN-1:0] r_data;
    logic [CHAIN_LEN-1:0] r_rsp;
    logic                 r_err;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_data  <= '0;
            r_rsp   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op   <= req_op;
                        r_data <= req_data;
                        r_rsp  <= '0;
                        r_cnt  <= '0;
                        case (req_op)
                            OP_SHIFT:   r_state <= S_SHIFT;
                            OP_ILLEGAL: begin
                                r_state <= S_RESP;
                                r_err   <= 1'b1;
                            end
                            default:    r_state <= S_CAPTURE;
                        endcase
                    end
                end
                S_CAPTURE: begin
                    r_state <= (r_op == OP_CAP_SH) ? S_SHIFT : S_RESP;
                end
                S_SHIFT: begin
                    // scan_out is the last cell's value during shift cycle k
                    r_rsp[r_cnt] <= scan_out;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin // S_RESP
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Every output is a pure decode of registers, so the chain sees no
    // combinational path from the request/response handshakes.
    assign w_shift   = (r_state == S_SHIFT);
    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign cap_en    = (r_state == S_CAPTURE);
    assign scan_en   = w_shift;
    assign scan_in   = w_shift & r_data[r_cnt];
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dff_scan_ctrl.sv
module tb_dff_scan_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [N-1:0] req_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_err;
    logic         cap_en;
    logic         scan_en;
    logic         scan_in;
    logic         scan_out;
    logic         busy;

    // chain model: cell 0 is first, scan_out comes from the last cell
    logic [N-1:0] chain;
    logic [N-1:0] par_in;

    typedef struct packed {
        logic [N-1:0] d;
        logic         e;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    dff_scan_ctrl #(.CHAIN_LEN(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cap_en(cap_en), .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst)          chain <= '0;
        else if (cap_en)  chain <= par_in;
        else if (scan_en) chain <= {chain[N-2:0], scan_in};
    end
    assign scan_out = chain[N-1];

    function automatic logic [N-1:0] rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[N-1-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept at edge T; leaves the bench sampling cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [N-1:0] data);
        exp_t x;
        int   w = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        while (!req_ready && w < 20) begin tick(); w++; end
        check("req_ready_wait", 64'(req_ready), 64'd1);
        x.e = (op == 2'b11);
        case (op)
            2'b00:   x.d = rev(chain);
            2'b01:   x.d = rev(par_in);
            default: x.d = '0;
        endcase
        sb.push_back(x);
        tick();
        req_valid = 1'b0;
    endtask

    // Watches cycles T+1.. until rsp_valid; cycle indices are relative to T.
    task automatic watch(input int exp_cap_at, input int exp_scan_first, input int exp_scan_n,
                         input int exp_rsp_at, input logic [N-1:0] exp_sin);
        int n = 1, cap_n = 0, cap_at = 0, sc_n = 0, sc_first = 0;
        logic ov = 1'b0;
        logic [N-1:0] sin = '0;
        while (!rsp_valid && n <= 40) begin
            if (cap_en) begin cap_n++; cap_at = n; end
            if (scan_en) begin
                if (sc_n == 0) sc_first = n;
                if (sc_n < N) sin[sc_n] = scan_in;
                sc_n++;
            end
            if (cap_en && scan_en) ov = 1'b1;
            tick();
            n++;
        end
        check("rsp_valid_cycle", 64'(n), 64'(exp_rsp_at));
        check("cap_en_count", 64'(cap_n), 64'((exp_cap_at != 0) ? 1 : 0));
        if (exp_cap_at != 0) check("cap_en_cycle", 64'(cap_at), 64'(exp_cap_at));
        check("scan_en_count", 64'(sc_n), 64'(exp_scan_n));
        if (exp_scan_n != 0) begin
            check("scan_en_first", 64'(sc_first), 64'(exp_scan_first));
            check("scan_in_seq", 64'(sin), 64'(exp_sin));
        end
        check("cap_scan_overlap", 64'(ov), 64'd0);
    endtask

    task automatic take_rsp();
        exp_t x;
        check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check("rsp_data", 64'(rsp_data), 64'(x.d));
            check("rsp_err", 64'(rsp_err), 64'(x.e));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_rsp_busy", 64'(busy), 64'd0);
        check("post_rsp_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [N-1:0] held;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = '0;
        rsp_ready = 1'b0; par_in = '0;
        tick(); tick();
        rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 5; i++) begin
            check("idle_req_ready", 64'(req_ready), 64'd1);
            check("idle_outs", 64'({busy, scan_en, cap_en, rsp_valid, rsp_err, scan_in}), 64'd0);
            check("idle_rsp_data", 64'(rsp_data), 64'd0);
            tick();
        end

        // op 00 twice: second response returns the first payload in order
        issue(2'b00, 8'hA5); watch(0, 1, N, N + 1, 8'hA5); take_rsp();
        issue(2'b00, 8'h00); watch(0, 1, N, N + 1, 8'h00); take_rsp();

        // op 01 capture + shift
        par_in = 8'h3C;
        issue(2'b01, 8'h96); watch(1, 2, N, N + 2, 8'h96); take_rsp();
        par_in = 8'hC1;
        issue(2'b01, 8'h0F); watch(1, 2, N, N + 2, 8'h0F); take_rsp();

        // illegal op, then capture-only with rsp_ready already high
        issue(2'b11, 8'hFF); watch(0, 0, 0, 1, 8'h00); take_rsp();
        rsp_ready = 1'b1;
        issue(2'b10, 8'h55); watch(1, 0, 0, 2, 8'h00); take_rsp();

        // backpressure in RESP with stray request pulses
        issue(2'b00, 8'h3A); watch(0, 1, N, N + 1, 8'h3A);
        held = rsp_data;
        for (int i = 0; i < 6; i++) begin
            req_valid = i[0]; req_op = 2'b11; req_data = 8'hFF;
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_data", 64'(rsp_data), 64'(held));
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_no_strobe", 64'({scan_en, cap_en}), 64'd0);
            tick();
        end
        // handshake edge with a request waiting: must not be accepted there
        req_valid = 1'b1;
        take_rsp();
        req_valid = 1'b0;
        check("no_accept_on_rsp", 64'(busy), 64'd0);

        // reset at shift cycle k=3
        issue(2'b00, 8'h5A);
        tick(); tick(); tick();
        check("k3_scan_en", 64'(scan_en), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_scan_en", 64'(scan_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_outs", 64'({rsp_valid, rsp_err, cap_en, scan_in, rsp_data}), 64'd0);
        void'(sb.pop_back());
        issue(2'b00, 8'hE7); watch(0, 1, N, N + 1, 8'hE7); take_rsp();
        issue(2'b00, 8'h00); watch(0, 1, N, N + 1, 8'h00); take_rsp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_scan_ctrl.md
Name: dff_scan_ctrl

Overview:
- Sequencer for a serial chain of wrapped D flip-flop cells. The cells share `clk`/`rst`, and their scan mux is driven by `scan_en`.
- Accepts shift / capture-and-shift requests over a valid/ready handshake.
- Drives `cap_en`, `scan_en` and `scan_in` for an exact number of cycles, and collects `scan_out` into a parallel response word.
- Sits between the test/config register file and the flip-flop bank.

Parameters:
- CHAIN_LEN, 8, number of flip-flop cells in the chain (legal range 2..64).
- CNT_W, $clog2(CHAIN_LEN), width of the internal shift-cycle counter (derived; not overridden).

Ports:
- clk  input  1  clock shared with the flip-flop chain
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_op  input  2  00=shift, 01=capture+shift, 10=capture only, 11=illegal
- req_data  input  CHAIN_LEN  serial data to shift in, bit 0 first
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  CHAIN_LEN  bits shifted out, bit 0 = first sampled
- rsp_err  output  1  request was illegal (op 11)
- cap_en  output  1  chain parallel-capture strobe
- scan_en  output  1  chain shift enable
- scan_in  output  1  serial input to first cell
- scan_out  input  1  serial output of last cell
- busy  output  1  high in any state except IDLE

Behaviour:
- Clock/reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; `req_ready`=1; `rsp_valid`, `rsp_err`, `cap_en`, `scan_en`, `scan_in`, `busy`=0; `rsp_data`=0; counter=0.
- States: IDLE, CAPTURE, SHIFT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready` at edge T, latch `req_op` and `req_data`.
  - Next state: op 01/10 -> CAPTURE; op 00 -> SHIFT; op 11 -> RESP with `rsp_err`=1.
  - `rsp_data` is cleared to 0 on accept.
- CAPTURE:
  - Exactly one cycle with `cap_en`=1 and `scan_en`=0.
  - Next state: op 01 -> SHIFT; op 10 -> RESP.
- SHIFT:
  - Exactly CHAIN_LEN cycles, indexed k=0..CHAIN_LEN-1.
  - In cycle k: `scan_en`=1, `scan_in`=req_data[k], `cap_en`=0.
  - At the edge ending cycle k, `rsp_data[k]` <= `scan_out`.
  - Counter increments per cycle; after k=CHAIN_LEN-1, counter returns to 0 and state goes to RESP.
- RESP:
  - `rsp_valid`=1 and `rsp_data`/`rsp_err` stable until `rsp_valid`&&`rsp_ready`.
  - Then -> IDLE, `rsp_valid`=0, `rsp_err`=0.
  - A new request is not accepted in the same cycle as the response handshake.
- `req_ready`=1 only in IDLE. `req_valid` outside IDLE is ignored and does not alter the latched request.
- `scan_en` and `cap_en` are never high together.
- All chain-facing outputs are registered (decoded from the registered state and counter).
- Latency, request accepted at edge T:
  - op 00: `scan_en` high cycles T+1..T+CHAIN_LEN; `rsp_valid` first high in cycle T+CHAIN_LEN+1.
  - op 01: `cap_en` high in cycle T+1; `scan_en` high cycles T+2..T+CHAIN_LEN+1; `rsp_valid` first high in cycle T+CHAIN_LEN+2.
  - op 10: `cap_en` high in cycle T+1; `rsp_valid` first high in cycle T+2; `rsp_data`=0.
  - op 11: `rsp_valid` first high in cycle T+1, `rsp_err`=1, no `cap_en`/`scan_en` activity.
- `rst` mid-operation: at the next edge, all outputs return to reset values, with no further `scan_en`/`cap_en` pulses. A pending response is dropped.
- `rsp_ready` held high before RESP has no effect. `rsp_ready` low stalls indefinitely in RESP with outputs held.
- Counter width: CNT_W bits; terminal compare against CHAIN_LEN-1. No overflow is possible.

Test Plan:
- Reset, then idle with `req_valid`=0 for 5 cycles -> `req_ready`=1, `busy`=0, `scan_en`=`cap_en`=`rsp_valid`=0 throughout.
- CHAIN_LEN=8, chain model preloaded 0x00, op 00, `req_data`=0xA5, then a second op 00 with `req_data`=0x00:
  - First request: `scan_en` high exactly 8 cycles; `scan_in` sequence 1,0,1,0,0,1,0,1; `rsp_valid` at T+9 with `rsp_data`=0x00.
  - Second request: `rsp_data`=0xA5 (bit order check).
- op 01 with chain model parallel input 0x3C -> `cap_en` single pulse at T+1; `scan_en` T+2..T+9; `rsp_data` = 0x3C mapped per chain order; `cap_en`/`scan_en` never overlap.
- op 11 -> `rsp_valid` at T+1 with `rsp_err`=1; zero `scan_en`/`cap_en` cycles. op 10 -> one `cap_en` pulse; `rsp_valid` at T+2 with `rsp_data`=0.
- Backpressure: `rsp_ready`=0 for 6 cycles in RESP -> `rsp_valid`, `rsp_data` stable; `req_ready`=0; `req_valid` pulses ignored. Raise `rsp_ready` -> IDLE the next cycle.
- Assert `rst` for one cycle at shift cycle k=3 of an op 00 -> next cycle `scan_en`=0, `busy`=0, `req_ready`=1; a fresh request then completes normally with 8 shift cycles.
